// File: rtl/pong_pkg.sv
// Shared definitions for the pong control front end: quadrature phase codes,
// button debounce states, decode helper and default timing constants that
// paddle_fsm also relies on.
package pong_pkg;

  // Gray-coded {A,B} phases in clockwise order: 00 -> 01 -> 11 -> 10 -> 00.
  localparam logic [1:0] QPHASE_00 = 2'b00;
  localparam logic [1:0] QPHASE_01 = 2'b01;
  localparam logic [1:0] QPHASE_11 = 2'b11;
  localparam logic [1:0] QPHASE_10 = 2'b10;

  // Default timing shared with paddle_fsm (75 MHz CLK).
  localparam int DEF_DEB_CYCLES  = 750000;  // 10 ms button debounce
  localparam int DEF_STEP_COUNT  = 4;       // quadrature transitions per detent
  localparam int DEF_FILT_LEN    = 4;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } btn_state_t;

  // Result of comparing the previous and current filtered phase.
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_FWD  = 2'd1,
    DIR_REV  = 2'd2,
    DIR_ILL  = 2'd3
  } qdir_t;

  // Classify one phase transition. Both bits changing together is illegal.
  function automatic qdir_t qdecode(input logic [1:0] prev, input logic [1:0] cur);
    qdir_t d;
    if (prev == cur) begin
      d = DIR_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      d = DIR_ILL;
    end else begin
      case (prev)
        QPHASE_00: d = (cur == QPHASE_01) ? DIR_FWD : DIR_REV;
        QPHASE_01: d = (cur == QPHASE_11) ? DIR_FWD : DIR_REV;
        QPHASE_11: d = (cur == QPHASE_10) ? DIR_FWD : DIR_REV;
        default:   d = (cur == QPHASE_00) ? DIR_FWD : DIR_REV;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: synchroniser, glitch filter, quadrature decode with a
// detent accumulator, sticky error flag and a push-button debounce FSM.
// The button FSM state is brought out on o_btn_state for observation.
module quad_channel
  import pong_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_LEN    = DEF_FILT_LEN,
  parameter int STEP_COUNT  = DEF_STEP_COUNT,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_enc_a,
  input  logic       i_enc_b,
  input  logic       i_btn,
  input  logic       i_err_clr,
  output logic       o_up,
  output logic       o_down,
  output logic       o_btn_press,
  output logic       o_btn_level,
  output logic       o_err,
  output btn_state_t o_btn_state
);

  localparam int FCW   = $clog2(FILT_LEN + 1);
  localparam int DCW   = $clog2(DEB_CYCLES + 1);
  localparam int ACC_W = $clog2(STEP_COUNT + 1) + 1;

  localparam logic [FCW-1:0]         FILT_LAST = FCW'(FILT_LEN - 1);
  localparam logic [DCW-1:0]         DEB_LAST  = DCW'(DEB_CYCLES - 1);
  localparam logic signed [ACC_W-1:0] ACC_TOP  = ACC_W'(STEP_COUNT - 1);
  localparam logic signed [ACC_W-1:0] ACC_BOT  = -ACC_TOP;
  localparam logic signed [ACC_W-1:0] ACC_ONE  = ACC_W'(1);

  // Bit layout used throughout: [2]=button, [1]=A, [0]=B, so [1:0] is the phase.
  logic [SYNC_STAGES-1:0][2:0] r_sync;
  logic [2:0]                  w_synced;
  logic [2:0]                  r_filt;
  logic [2:0][FCW-1:0]         r_fcnt;

  logic                        r_init;
  logic [1:0]                  r_prev;
  logic signed [ACC_W-1:0]     r_acc;
  logic                        r_up;
  logic                        r_down;
  logic                        r_err;
  qdir_t                       w_dir;

  btn_state_t                  r_state;
  btn_state_t                  w_state_nxt;
  logic [DCW-1:0]              r_cnt;
  logic [DCW-1:0]              w_cnt_nxt;
  logic                        w_press;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_dir    = qdecode(r_prev, r_filt[1:0]);

  // Shift the raw asynchronous inputs through the synchroniser chain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= {i_btn, i_enc_a, i_enc_b};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Per-bit filter: follow the synced bit only after FILT_LEN disagreeing cycles in a row.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_filt <= '0;
      r_fcnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_synced[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FILT_LAST) begin
          r_filt[i] <= w_synced[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + FCW'(1);
        end
      end
    end
  end

  // Decode phase steps into the detent accumulator; emit UP/DOWN and track errors.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_init <= 1'b1;
      r_prev <= '0;
      r_acc  <= '0;
      r_up   <= 1'b0;
      r_down <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_up   <= 1'b0;
      r_down <= 1'b0;
      r_prev <= r_filt[1:0];
      r_init <= 1'b0;
      if (!r_init) begin
        case (w_dir)
          DIR_FWD: begin
            if (r_acc == ACC_TOP) begin
              r_up  <= 1'b1;
              r_acc <= '0;
            end else begin
              r_acc <= r_acc + ACC_ONE;
            end
          end
          DIR_REV: begin
            if (r_acc == ACC_BOT) begin
              r_down <= 1'b1;
              r_acc  <= '0;
            end else begin
              r_acc <= r_acc - ACC_ONE;
            end
          end
          default: ;
        endcase
      end
      // A new error outranks a simultaneous clear.
      if (!r_init && (w_dir == DIR_ILL)) r_err <= 1'b1;
      else if (i_err_clr)                r_err <= 1'b0;
    end
  end

  // Button FSM state and debounce counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Button FSM next state; the press pulse fires on the PRESS_WAIT -> HELD move.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_filt[2]) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!r_filt[2]) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = HELD;
          w_press     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + DCW'(1);
        end
      end
      HELD: begin
        if (!r_filt[2]) begin
          w_state_nxt = REL_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      REL_WAIT: begin
        if (r_filt[2]) begin
          w_state_nxt = HELD;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + DCW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_up        = r_up;
  assign o_down      = r_down;
  assign o_err       = r_err;
  assign o_btn_press = w_press;
  assign o_btn_level = (r_state == HELD) || (r_state == REL_WAIT);
  assign o_btn_state = r_state;

endmodule

// File: rtl/quad_encoder_bank.sv
// Multi-channel rotary encoder front end for the pong controls. Each channel
// is an independent quad_channel; ERR_CLR is shared by all of them.
// DBG_BTN_STATE packs each channel's button FSM state, 2 bits per channel.
module quad_encoder_bank
  import pong_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_LEN    = DEF_FILT_LEN,
  parameter int STEP_COUNT  = DEF_STEP_COUNT,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_CH-1:0]   ENC_A,
  input  logic [N_CH-1:0]   ENC_B,
  input  logic [N_CH-1:0]   BTN,
  input  logic              ERR_CLR,
  output logic [N_CH-1:0]   UP,
  output logic [N_CH-1:0]   DOWN,
  output logic [N_CH-1:0]   BTN_PRESS,
  output logic [N_CH-1:0]   BTN_LEVEL,
  output logic [N_CH-1:0]   ERR,
  output logic [2*N_CH-1:0] DBG_BTN_STATE
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_state_t w_state;

    quad_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .STEP_COUNT  (STEP_COUNT),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_ch (
      .CLK         (CLK),
      .RST         (RST),
      .i_enc_a     (ENC_A[g]),
      .i_enc_b     (ENC_B[g]),
      .i_btn       (BTN[g]),
      .i_err_clr   (ERR_CLR),
      .o_up        (UP[g]),
      .o_down      (DOWN[g]),
      .o_btn_press (BTN_PRESS[g]),
      .o_btn_level (BTN_LEVEL[g]),
      .o_err       (ERR[g]),
      .o_btn_state (w_state)
    );

    assign DBG_BTN_STATE[2*g +: 2] = w_state;
  end

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Directed bench for quad_encoder_bank with short sim timing
// (FILT_LEN=4, STEP_COUNT=4, DEB_CYCLES=16). Inputs change 1 time unit after
// a rising edge; outputs are sampled at the same point after later edges.
module tb_quad_encoder_bank;

  localparam int N_CH = 2;

  logic       CLK;
  logic       RST;
  logic [1:0] ENC_A;
  logic [1:0] ENC_B;
  logic [1:0] BTN;
  logic       ERR_CLR;
  logic [1:0] UP;
  logic [1:0] DOWN;
  logic [1:0] BTN_PRESS;
  logic [1:0] BTN_LEVEL;
  logic [1:0] ERR;
  logic [3:0] DBG_BTN_STATE;

  int n_cmp = 0;
  int n_err = 0;

  int up_cnt    [2] = '{0, 0};
  int down_cnt  [2] = '{0, 0};
  int press_cnt [2] = '{0, 0};
  int both_cnt      = 0;

  quad_encoder_bank #(
    .N_CH        (N_CH),
    .SYNC_STAGES (2),
    .FILT_LEN    (4),
    .STEP_COUNT  (4),
    .DEB_CYCLES  (16)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ENC_A         (ENC_A),
    .ENC_B         (ENC_B),
    .BTN           (BTN),
    .ERR_CLR       (ERR_CLR),
    .UP            (UP),
    .DOWN          (DOWN),
    .BTN_PRESS     (BTN_PRESS),
    .BTN_LEVEL     (BTN_LEVEL),
    .ERR           (ERR),
    .DBG_BTN_STATE (DBG_BTN_STATE)
  );

  // clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // pulse counters, sampled mid-cycle
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      for (int c = 0; c < 2; c++) begin
        if (UP[c] === 1'b1)                       up_cnt[c]++;
        if (DOWN[c] === 1'b1)                     down_cnt[c]++;
        if (BTN_PRESS[c] === 1'b1)                press_cnt[c]++;
        if (UP[c] === 1'b1 && DOWN[c] === 1'b1)   both_cnt++;
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic set_ph(input logic [1:0] p0, input logic [1:0] p1);
    ENC_A = {p1[1], p0[1]};
    ENC_B = {p1[0], p0[0]};
  endtask

  task automatic test_reset();
    RST = 1'b1; ENC_A = 2'b00; ENC_B = 2'b00; BTN = 2'b00; ERR_CLR = 1'b0;
    tick(3);
    n_cmp++; if (UP !== 2'b00)        begin n_err++; $display("FAIL reset_up: got %b want 00", UP); end
    n_cmp++; if (DOWN !== 2'b00)      begin n_err++; $display("FAIL reset_down: got %b want 00", DOWN); end
    n_cmp++; if (BTN_PRESS !== 2'b00) begin n_err++; $display("FAIL reset_press: got %b want 00", BTN_PRESS); end
    n_cmp++; if (BTN_LEVEL !== 2'b00) begin n_err++; $display("FAIL reset_level: got %b want 00", BTN_LEVEL); end
    n_cmp++; if (ERR !== 2'b00)       begin n_err++; $display("FAIL reset_err: got %b want 00", ERR); end
    n_cmp++; if (DBG_BTN_STATE !== 4'h0) begin n_err++; $display("FAIL reset_state: got %h want 0", DBG_BTN_STATE); end
    RST = 1'b0;
    tick(10);
  endtask

  task automatic test_forward();
    int u0, d0;
    u0 = up_cnt[0]; d0 = down_cnt[0] + down_cnt[1];
    set_ph(2'b01, 2'b00); tick(20);
    set_ph(2'b11, 2'b00); tick(20);
    set_ph(2'b10, 2'b00); tick(20);
    n_cmp++; if (up_cnt[0] - u0 != 0) begin n_err++; $display("FAIL fwd_no_early_up: got %0d want 0", up_cnt[0] - u0); end
    set_ph(2'b00, 2'b00);
    tick(6);
    n_cmp++; if (UP !== 2'b00) begin n_err++; $display("FAIL fwd_latency_early: got %b want 00", UP); end
    tick(1);
    n_cmp++; if (UP !== 2'b01) begin n_err++; $display("FAIL fwd_latency_exact: got %b want 01", UP); end
    tick(1);
    n_cmp++; if (UP !== 2'b00) begin n_err++; $display("FAIL fwd_pulse_width: got %b want 00", UP); end
    tick(12);
    n_cmp++; if (up_cnt[0] - u0 != 1) begin n_err++; $display("FAIL fwd_up_count: got %0d want 1", up_cnt[0] - u0); end
    n_cmp++; if (down_cnt[0] + down_cnt[1] - d0 != 0) begin n_err++; $display("FAIL fwd_no_down: got %0d want 0", down_cnt[0] + down_cnt[1] - d0); end
    n_cmp++; if (ERR !== 2'b00) begin n_err++; $display("FAIL fwd_err: got %b want 00", ERR); end
  endtask

  task automatic test_dual();
    logic [1:0] fwd [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] rev [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    int u0, u1, d0, d1;
    u0 = up_cnt[0]; u1 = up_cnt[1]; d0 = down_cnt[0]; d1 = down_cnt[1];
    for (int i = 0; i < 3; i++) begin
      set_ph(fwd[i], rev[i]);
      tick(20);
    end
    n_cmp++; if ((up_cnt[0] - u0) + (down_cnt[1] - d1) != 0) begin n_err++; $display("FAIL dual_no_early: got %0d want 0", (up_cnt[0] - u0) + (down_cnt[1] - d1)); end
    set_ph(fwd[3], rev[3]);
    tick(7);
    n_cmp++; if (UP !== 2'b01)   begin n_err++; $display("FAIL dual_up_same_cycle: got %b want 01", UP); end
    n_cmp++; if (DOWN !== 2'b10) begin n_err++; $display("FAIL dual_down_same_cycle: got %b want 10", DOWN); end
    tick(13);
    n_cmp++; if (up_cnt[0] - u0 != 1)   begin n_err++; $display("FAIL dual_up0: got %0d want 1", up_cnt[0] - u0); end
    n_cmp++; if (up_cnt[1] - u1 != 0)   begin n_err++; $display("FAIL dual_up1: got %0d want 0", up_cnt[1] - u1); end
    n_cmp++; if (down_cnt[0] - d0 != 0) begin n_err++; $display("FAIL dual_down0: got %0d want 0", down_cnt[0] - d0); end
    n_cmp++; if (down_cnt[1] - d1 != 1) begin n_err++; $display("FAIL dual_down1: got %0d want 1", down_cnt[1] - d1); end
    n_cmp++; if (ERR !== 2'b00)         begin n_err++; $display("FAIL dual_err: got %b want 00", ERR); end
  endtask

  task automatic test_glitch();
    int u0, d0;
    u0 = up_cnt[0]; d0 = down_cnt[0];
    // two forward, two back: accumulator returns to zero
    set_ph(2'b01, 2'b00); tick(20);
    set_ph(2'b11, 2'b00); tick(20);
    set_ph(2'b01, 2'b00); tick(20);
    set_ph(2'b00, 2'b00); tick(20);
    n_cmp++; if ((up_cnt[0] - u0) + (down_cnt[0] - d0) != 0) begin n_err++; $display("FAIL glitch_fb_no_pulse: got %0d want 0", (up_cnt[0] - u0) + (down_cnt[0] - d0)); end
    // three forward from zero: still one short of a detent
    set_ph(2'b01, 2'b00); tick(20);
    set_ph(2'b11, 2'b00); tick(20);
    set_ph(2'b10, 2'b00); tick(20);
    n_cmp++; if (up_cnt[0] - u0 != 0) begin n_err++; $display("FAIL glitch_acc_zero: got %0d want 0", up_cnt[0] - u0); end
    // 3-cycle glitch on A toward 00 would complete the detent if it got through
    ENC_A[0] = 1'b0; tick(3);
    ENC_A[0] = 1'b1; tick(20);
    n_cmp++; if (up_cnt[0] - u0 != 0) begin n_err++; $display("FAIL glitch_filtered: got %0d want 0", up_cnt[0] - u0); end
    n_cmp++; if (ERR !== 2'b00)       begin n_err++; $display("FAIL glitch_err: got %b want 00", ERR); end
    set_ph(2'b00, 2'b00);
    tick(7);
    n_cmp++; if (UP !== 2'b01) begin n_err++; $display("FAIL glitch_detent_up: got %b want 01", UP); end
    tick(13);
    n_cmp++; if (up_cnt[0] - u0 != 1) begin n_err++; $display("FAIL glitch_up_count: got %0d want 1", up_cnt[0] - u0); end
  endtask

  task automatic test_err();
    int u0, d0;
    u0 = up_cnt[0]; d0 = down_cnt[0];
    set_ph(2'b11, 2'b00); tick(10);
    n_cmp++; if (ERR !== 2'b01) begin n_err++; $display("FAIL err_set: got %b want 01", ERR); end
    n_cmp++; if ((up_cnt[0] - u0) + (down_cnt[0] - d0) != 0) begin n_err++; $display("FAIL err_no_pulse: got %0d want 0", (up_cnt[0] - u0) + (down_cnt[0] - d0)); end
    tick(20);
    n_cmp++; if (ERR !== 2'b01) begin n_err++; $display("FAIL err_sticky: got %b want 01", ERR); end
    // second illegal step lands in the same cycle as ERR_CLR
    set_ph(2'b00, 2'b00);
    tick(6);
    ERR_CLR = 1'b1; tick(1); ERR_CLR = 1'b0;
    n_cmp++; if (ERR !== 2'b01) begin n_err++; $display("FAIL err_set_wins: got %b want 01", ERR); end
    tick(5);
    ERR_CLR = 1'b1; tick(1); ERR_CLR = 1'b0;
    n_cmp++; if (ERR !== 2'b00) begin n_err++; $display("FAIL err_clear: got %b want 00", ERR); end
    tick(2);
    n_cmp++; if (ERR !== 2'b00) begin n_err++; $display("FAIL err_stays_clear: got %b want 00", ERR); end
    // accumulator untouched by the illegal steps, tracking resumes from 00
    set_ph(2'b01, 2'b00); tick(20);
    set_ph(2'b11, 2'b00); tick(20);
    set_ph(2'b10, 2'b00); tick(20);
    n_cmp++; if (up_cnt[0] - u0 != 0) begin n_err++; $display("FAIL err_acc_kept: got %0d want 0", up_cnt[0] - u0); end
    set_ph(2'b00, 2'b00);
    tick(7);
    n_cmp++; if (UP !== 2'b01) begin n_err++; $display("FAIL err_resume_up: got %b want 01", UP); end
    tick(13);
  endtask

  task automatic test_button();
    int p0, p1;
    p0 = press_cnt[0]; p1 = press_cnt[1];
    for (int i = 0; i < 3; i++) begin
      BTN[0] = 1'b1; tick(5);
      BTN[0] = 1'b0; tick(5);
    end
    n_cmp++; if (press_cnt[0] - p0 != 0) begin n_err++; $display("FAIL btn_bounce_no_press: got %0d want 0", press_cnt[0] - p0); end
    n_cmp++; if (BTN_LEVEL !== 2'b00)    begin n_err++; $display("FAIL btn_bounce_level: got %b want 00", BTN_LEVEL); end
    BTN[0] = 1'b1;
    tick(21);
    n_cmp++; if (BTN_PRESS !== 2'b00) begin n_err++; $display("FAIL btn_press_early: got %b want 00", BTN_PRESS); end
    tick(1);
    n_cmp++; if (BTN_PRESS !== 2'b01) begin n_err++; $display("FAIL btn_press_exact: got %b want 01", BTN_PRESS); end
    tick(1);
    n_cmp++; if (BTN_PRESS !== 2'b00)      begin n_err++; $display("FAIL btn_press_width: got %b want 00", BTN_PRESS); end
    n_cmp++; if (BTN_LEVEL !== 2'b01)      begin n_err++; $display("FAIL btn_level_high: got %b want 01", BTN_LEVEL); end
    n_cmp++; if (DBG_BTN_STATE !== 4'h2)   begin n_err++; $display("FAIL btn_state_held: got %h want 2", DBG_BTN_STATE); end
    tick(20);
    n_cmp++; if (press_cnt[0] - p0 != 1) begin n_err++; $display("FAIL btn_press_count: got %0d want 1", press_cnt[0] - p0); end
    n_cmp++; if (press_cnt[1] - p1 != 0) begin n_err++; $display("FAIL btn_crosstalk: got %0d want 0", press_cnt[1] - p1); end
    for (int i = 0; i < 2; i++) begin
      BTN[0] = 1'b0; tick(5);
      BTN[0] = 1'b1; tick(5);
    end
    n_cmp++; if (BTN_LEVEL !== 2'b01) begin n_err++; $display("FAIL btn_release_bounce: got %b want 01", BTN_LEVEL); end
    BTN[0] = 1'b0;
    tick(22);
    n_cmp++; if (BTN_LEVEL !== 2'b01) begin n_err++; $display("FAIL btn_release_early: got %b want 01", BTN_LEVEL); end
    tick(1);
    n_cmp++; if (BTN_LEVEL !== 2'b00)    begin n_err++; $display("FAIL btn_release_exact: got %b want 00", BTN_LEVEL); end
    n_cmp++; if (DBG_BTN_STATE !== 4'h0) begin n_err++; $display("FAIL btn_state_idle: got %h want 0", DBG_BTN_STATE); end
    n_cmp++; if (press_cnt[0] - p0 != 1) begin n_err++; $display("FAIL btn_no_extra_press: got %0d want 1", press_cnt[0] - p0); end
  endtask

  task automatic test_reset_mid();
    int u0, d0, p0;
    u0 = up_cnt[0] + up_cnt[1]; d0 = down_cnt[0] + down_cnt[1];
    // partial detent (+2) and a held button before reset
    set_ph(2'b01, 2'b00); tick(20);
    set_ph(2'b11, 2'b00); tick(20);
    BTN[0] = 1'b1; tick(30);
    n_cmp++; if (BTN_LEVEL !== 2'b01) begin n_err++; $display("FAIL rst_pre_level: got %b want 01", BTN_LEVEL); end
    RST = 1'b1;
    #1;
    n_cmp++; if (BTN_LEVEL !== 2'b00)    begin n_err++; $display("FAIL rst_async_level: got %b want 00", BTN_LEVEL); end
    n_cmp++; if ({UP, DOWN, BTN_PRESS, ERR} !== 8'h00) begin n_err++; $display("FAIL rst_async_outs: got %h want 00", {UP, DOWN, BTN_PRESS, ERR}); end
    n_cmp++; if (DBG_BTN_STATE !== 4'h0) begin n_err++; $display("FAIL rst_async_state: got %h want 0", DBG_BTN_STATE); end
    tick(3);
    RST = 1'b0;
    p0 = press_cnt[0];
    tick(21);
    n_cmp++; if (BTN_PRESS !== 2'b00) begin n_err++; $display("FAIL rst_press_early: got %b want 00", BTN_PRESS); end
    tick(1);
    n_cmp++; if (BTN_PRESS !== 2'b01) begin n_err++; $display("FAIL rst_press_redebounce: got %b want 01", BTN_PRESS); end
    tick(20);
    ERR_CLR = 1'b1; tick(1); ERR_CLR = 1'b0;
    // two more forward steps: would complete a detent only if the old +2 survived
    set_ph(2'b10, 2'b00); tick(20);
    set_ph(2'b00, 2'b00); tick(20);
    n_cmp++; if (up_cnt[0] + up_cnt[1] - u0 != 0)     begin n_err++; $display("FAIL rst_no_up: got %0d want 0", up_cnt[0] + up_cnt[1] - u0); end
    n_cmp++; if (down_cnt[0] + down_cnt[1] - d0 != 0) begin n_err++; $display("FAIL rst_no_down: got %0d want 0", down_cnt[0] + down_cnt[1] - d0); end
    n_cmp++; if (press_cnt[0] - p0 != 1)              begin n_err++; $display("FAIL rst_press_count: got %0d want 1", press_cnt[0] - p0); end
  endtask

  task automatic test_exclusive();
    n_cmp++; if (both_cnt != 0) begin n_err++; $display("FAIL up_down_exclusive: got %0d want 0", both_cnt); end
  endtask

  // test sequence and final report
  initial begin
    test_reset();
    test_forward();
    test_dual();
    test_glitch();
    test_err();
    test_button();
    test_reset_mid();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
